seq_multiplier: RTL and testbench

- Parametrised sequential radix-2 shift-add multiplier: WIDTH x WIDTH operands, 2*WIDTH-bit product.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Start/busy/done handshake trades latency for area; sits in datapaths where one multiply per WIDTH+1 cycles is enough.

---
 rtl/seq_multiplier.sv | 120 ++++++++++++
 tb/tb_seq_multiplier.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier.
//
// One WIDTH x WIDTH multiply per WIDTH+1 cycles, unsigned or two's-complement
// selected per operation. Signed operands are reduced to magnitudes at accept
// time, multiplied unsigned, and the result negated at the end if needed.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request; accepted in IDLE or DONE, ignored while busy
//   signed_mode 1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a, b        multiplicand / multiplier (sampled with start)
//   busy        high while the operation is iterating
//   done        one-cycle pulse when product is valid
//   product     2*WIDTH-bit result, held until the next result is written
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   count;
  logic            neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    result;
  logic             last_iter;

  // -2^(WIDTH-1) negates to itself in WIDTH bits, which read as unsigned is
  // exactly its magnitude, so no extra bit is needed.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (signed_mode && a[WIDTH-1]) a_mag = (~a) + WIDTH'(1);
    if (signed_mode && b[WIDTH-1]) b_mag = (~b) + WIDTH'(1);
  end

  // The final iteration's partial product is folded in combinationally so the
  // product can be written on the same edge as the last accumulate.
  always_comb begin
    acc_next  = acc;
    if (mplier[0]) acc_next = acc + mcand;
    result    = acc_next;
    if (neg) result = (~acc_next) + PW'(1);
    last_iter = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            count  <= '0;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last_iter) begin
            product <= result;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases at WIDTH=8, random
// operations against an integer reference model, and an exhaustive WIDTH=4
// sweep in both modes.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic        sm8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] prod8;

  logic        start4 = 1'b0;
  logic        sm4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        busy4;
  logic        done4;
  logic [7:0]  prod4;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret operands as integers per mode, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input int unsigned w, input logic [63:0] ra,
                                          input logic [63:0] rb, input bit sm);
    longint sa, sb, p;
    sa = longint'(ra);
    sb = longint'(rb);
    if (sm && ra[w-1]) sa = sa - (longint'(1) << w);
    if (sm && rb[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input bit tsm,
                      input logic [15:0] exp, input string tag, input bit pulse_mid);
    int bc;
    int extra;
    bit seen;
    bit both;
    @(negedge clk);
    a8 = ta; b8 = tb; sm8 = tsm; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    bc = 0; seen = 0; both = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy8 === 1'b1 && done8 === 1'b1) both = 1;
      if (done8 === 1'b1) begin seen = 1; break; end
      if (busy8 === 1'b1) bc++;
      if (pulse_mid && i == 3) begin start8 = 1'b1; a8 = 8'd9; b8 = 8'd9; sm8 = 1'b0; end
      else if (pulse_mid && i == 4) start8 = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(bc), 64'd8);
    chk({tag, "_busy_done_overlap"}, 64'(both), 64'd0);
    chk({tag, "_product"}, 64'(prod8), 64'(exp));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done8), 64'd0);
    if (pulse_mid) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        if (done8 === 1'b1 || busy8 === 1'b1) extra++;
        @(negedge clk);
      end
      chk({tag, "_no_second_op"}, 64'(extra), 64'd0);
      chk({tag, "_product_held"}, 64'(prod8), 64'(exp));
    end
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input bit tsm,
                      input logic [7:0] exp, input string tag);
    int bc;
    bit seen;
    @(negedge clk);
    a4 = ta; b4 = tb; sm4 = tsm; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    bc = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done4 === 1'b1) begin seen = 1; break; end
      if (busy4 === 1'b1) bc++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(seen ? bc : -1), 64'd4);
    chk({tag, "_product"}, 64'(prod4), 64'(exp));
  endtask

  int  bc;
  bit  stable;
  bit  seen;
  logic [7:0] ra, rb;
  bit  rsm;

  initial begin
    // Reset state
    #1;
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_prod8", 64'(prod8), 64'd0);
    chk("rst_busy4", 64'(busy4), 64'd0);
    chk("rst_prod4", 64'(prod4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned basics
    run8(8'd3,   8'd2,   1'b0, 16'h0006, "u_3x2",     1'b0);
    run8(8'd15,  8'd15,  1'b0, 16'h00E1, "u_15x15",   1'b0);
    run8(8'd255, 8'd255, 1'b0, 16'hFE01, "u_255x255", 1'b0);

    // Signed
    run8(8'hFD, 8'd5,   1'b1, 16'hFFF1, "s_m3x5",      1'b0);
    run8(8'h80, 8'h80,  1'b1, 16'h4000, "s_m128xm128", 1'b0);
    run8(8'h80, 8'd127, 1'b1, 16'hC080, "s_m128x127",  1'b0);
    run8(8'd0,  8'hF9,  1'b1, 16'h0000, "s_0xm7",      1'b0);

    // Start pulsed mid-operation must be ignored
    run8(8'd7, 8'd5, 1'b0, 16'h0023, "ignored_start", 1'b1);

    // Back-to-back: start held high through DONE
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd5; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'd8; b8 = 8'd4;
    bc = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done8 === 1'b1) begin seen = 1; break; end
      if (busy8 === 1'b1) bc++;
      @(negedge clk);
    end
    chk("b2b_first_lat", 64'(seen ? bc : -1), 64'd8);
    chk("b2b_first_product", 64'(prod8), 64'h23);
    @(negedge clk);
    chk("b2b_no_idle_busy", 64'(busy8), 64'd1);
    chk("b2b_no_idle_done", 64'(done8), 64'd0);
    start8 = 1'b0;
    bc = 0; seen = 0; stable = 1;
    for (int i = 0; i < 40; i++) begin
      if (done8 === 1'b1) begin seen = 1; break; end
      if (prod8 !== 16'h0023) stable = 0;
      if (busy8 === 1'b1) bc++;
      @(negedge clk);
    end
    chk("b2b_first_stable", 64'(stable), 64'd1);
    chk("b2b_second_lat", 64'(seen ? bc : -1), 64'd8);
    chk("b2b_second_product", 64'(prod8), 64'h20);
    @(negedge clk);

    // Asynchronous reset two cycles into CALC
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd5; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    chk("midrst_busy_before", 64'(busy8), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy8), 64'd0);
    chk("midrst_done", 64'(done8), 64'd0);
    chk("midrst_prod", 64'(prod8), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'd200, 8'd3, 1'b0, 16'h0258, "post_rst", 1'b0);

    // Random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rsm = 1'($urandom_range(0, 1));
      run8(ra, rb, rsm, 16'(ref_mul(8, 64'(ra), 64'(rb), rsm)), "rand8", 1'b0);
    end

    // WIDTH=4 exhaustive sweep in both modes
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          run4(4'(i), 4'(j), 1'(m), 8'(ref_mul(4, 64'(i), 64'(j), 1'(m))), "sweep4");
        end
      end
    end
    run4(4'h8, 4'h8, 1'b1, 8'h40, "s4_m8xm8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
